// File: rtl/dm_unit_if.sv
// dm_unit_if: datapath <-> data-memory port bundle (datapath is master, memory is slave)
interface dm_unit_if;
    logic [31:0] PC;
    logic [31:0] DMAdr;
    logic [31:0] DMDataW;
    logic        MemWrite;
    logic [2:0]  MemOp;
    logic [31:0] DMDataR;
    logic        AddrErr;
    logic        ErrSticky;
    logic [31:0] StoreCnt;

    modport master (
        output PC, DMAdr, DMDataW, MemWrite, MemOp,
        input  DMDataR, AddrErr, ErrSticky, StoreCnt
    );

    modport slave (
        input  PC, DMAdr, DMDataW, MemWrite, MemOp,
        output DMDataR, AddrErr, ErrSticky, StoreCnt
    );
endinterface

// File: rtl/dm_unit.sv
// dm_unit: data memory with sized/signed loads, byte-lane stores, error flags; DM_DISPLAY_EN enables a store log
module dm_unit #(
    parameter int          DEPTH     = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     reset,
    dm_unit_if.slave bus
);
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       off, rd_word, wr_mask, wr_data, word_d;
    logic [31:0]       store_cnt_q, store_cnt_d;
    logic [15:0]       rd_half;
    logic [7:0]        rd_byte;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              is_word, is_half, addr_err, wr_en;
    logic              err_sticky_q, err_sticky_d;

    // Address decode, load extraction and merged store word
    always_comb begin
        off          = bus.DMAdr - BASE_ADDR;
        idx          = off[ADDR_W+1:2];
        lane         = off[1:0];
        is_word      = bus.MemOp == 3'd0;
        is_half      = bus.MemOp == 3'd1 || bus.MemOp == 3'd2;
        addr_err     = (off >= 32'(4 * DEPTH)) || (is_word && lane != 2'd0) ||
                       (is_half && lane[0]) || (bus.MemOp > 3'd4);
        rd_word      = mem_q[idx];
        rd_half      = rd_word[{lane[1], 4'b0000} +: 16];
        rd_byte      = rd_word[{lane, 3'b000} +: 8];
        bus.DMDataR  = addr_err            ? 32'd0 :
                       is_word             ? rd_word :
                       bus.MemOp == 3'd1   ? {{16{rd_half[15]}}, rd_half} :
                       bus.MemOp == 3'd2   ? {16'd0, rd_half} :
                       bus.MemOp == 3'd3   ? {{24{rd_byte[7]}}, rd_byte} :
                                             {24'd0, rd_byte};
        wr_mask      = is_word ? 32'hFFFF_FFFF :
                       is_half ? (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) :
                                 32'h0000_00FF << {lane, 3'b000};
        wr_data      = is_word ? bus.DMDataW :
                       is_half ? {2{bus.DMDataW[15:0]}} : {4{bus.DMDataW[7:0]}};
        word_d       = (wr_data & wr_mask) | (rd_word & ~wr_mask);
        wr_en        = bus.MemWrite && !addr_err && !reset;
        err_sticky_d = err_sticky_q || addr_err;
        store_cnt_d  = store_cnt_q + 32'(wr_en);
        bus.AddrErr  = addr_err;
        bus.ErrSticky = err_sticky_q;
        bus.StoreCnt = store_cnt_q;
    end

    // Memory array, sticky error and store counter; reset clears everything and blocks stores
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            err_sticky_q <= 1'b0;
            store_cnt_q  <= '0;
        end else begin
            if (wr_en) mem_q[idx] <= word_d;
`ifdef DM_DISPLAY_EN
            if (wr_en) $display("%d@%h: *%h <= %h", $time, bus.PC, BASE_ADDR + {off[31:2], 2'b00}, word_d);
`endif
            err_sticky_q <= err_sticky_d;
            store_cnt_q  <= store_cnt_d;
        end
    end
endmodule
